// File: rtl/nx_fifo_1rw_ctl.sv
// Valid/ready FIFO controller around a single-port RAM with a 1-cycle read.
// One RAM op per cycle; a 2-entry output buffer hides the read latency.
module nx_fifo_1rw_ctl #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter bit INIT_ZERO = 1'b1,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 3)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             init_done,
    output logic             ram_cs,
    output logic             ram_we,
    output logic [AW-1:0]    ram_add,
    output logic [WIDTH-1:0] ram_bwe,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout
);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           r_state;
    logic [AW-1:0]    r_init_ctr;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_ram_cnt;
    logic             r_inflight;
    logic             r_last_rd;
    logic             r_init_done;
    logic [1:0]       r_ob_cnt;
    logic [WIDTH-1:0] r_ob0;
    logic [WIDTH-1:0] r_ob1;

    logic w_run;
    logic w_init;
    logic w_ob_room;
    logic w_rd_req;
    logic w_wr_rdy;
    logic w_push;
    logic w_wr_en;
    logic w_rd_en;
    logic w_pop;
    logic w_enq;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_run     = !rst && (r_state == ST_RUN);
    assign w_init    = !rst && (r_state == ST_INIT);
    // buffer slots already claimed include the read still in the RAM
    assign w_ob_room = (r_ob_cnt == 2'd0) ||
                       (r_ob_cnt == 2'd1 && !r_inflight);
    assign w_rd_req  = w_run && (r_ram_cnt != '0) && w_ob_room;
    assign w_wr_rdy  = w_run && (r_ram_cnt < CW'(DEPTH)) &&
                       (!w_rd_req || r_last_rd);
    assign w_push    = wr_valid && w_wr_rdy;
    assign w_wr_en   = w_push && !flush;
    assign w_rd_en   = w_rd_req && !w_push && !flush;
    assign w_pop     = rd_ready && (r_ob_cnt != 2'd0);
    assign w_enq     = r_inflight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= INIT_ZERO ? ST_INIT : ST_RUN;
            r_init_ctr  <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_cnt   <= '0;
            r_inflight  <= 1'b0;
            r_last_rd   <= 1'b0;
            r_init_done <= 1'b0;
            r_ob_cnt    <= 2'd0;
            r_ob0       <= '0;
            r_ob1       <= '0;
        end else if (r_state == ST_INIT) begin
            if (r_init_ctr == AW'(DEPTH - 1)) begin
                r_init_ctr  <= '0;
                r_state     <= ST_RUN;
                r_init_done <= 1'b1;
            end else begin
                r_init_ctr <= r_init_ctr + 1'b1;
            end
        end else begin
            r_init_done <= 1'b1;
            if (flush) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_ram_cnt  <= '0;
                r_inflight <= 1'b0;
                r_ob_cnt   <= 2'd0;
            end else begin
                r_inflight <= w_rd_en;
                if (w_wr_en) begin
                    r_wr_ptr  <= ptr_inc(r_wr_ptr);
                    r_last_rd <= 1'b0;
                    r_ram_cnt <= r_ram_cnt + 1'b1;
                end else if (w_rd_en) begin
                    r_rd_ptr  <= ptr_inc(r_rd_ptr);
                    r_last_rd <= 1'b1;
                    r_ram_cnt <= r_ram_cnt - 1'b1;
                end
                unique case ({w_pop, w_enq})
                    2'b11: begin
                        if (r_ob_cnt == 2'd2) begin
                            r_ob0 <= r_ob1;
                            r_ob1 <= ram_dout;
                        end else begin
                            r_ob0 <= ram_dout;
                        end
                    end
                    2'b10: begin
                        if (r_ob_cnt == 2'd2)
                            r_ob0 <= r_ob1;
                        r_ob_cnt <= r_ob_cnt - 1'b1;
                    end
                    2'b01: begin
                        if (r_ob_cnt == 2'd0)
                            r_ob0 <= ram_dout;
                        else
                            r_ob1 <= ram_dout;
                        r_ob_cnt <= r_ob_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign wr_ready  = w_wr_rdy;
    assign rd_valid  = (r_ob_cnt != 2'd0);
    assign rd_data   = r_ob0;
    assign count     = r_ram_cnt + CW'(r_inflight) + CW'(r_ob_cnt);
    assign init_done = r_init_done;
    assign ram_cs    = w_init || w_wr_en || w_rd_en;
    assign ram_we    = w_init || w_wr_en;
    assign ram_add   = w_init ? r_init_ctr :
                       (w_wr_en ? r_wr_ptr : r_rd_ptr);
    assign ram_bwe   = '1;
    assign ram_din   = w_init ? '0 : wr_data;

    // popping an empty buffer must leave it empty
    a_pop_empty: assert property (@(posedge clk) disable iff (rst)
        (rd_ready && !rd_valid && !r_inflight) |=> (r_ob_cnt == 2'd0));
    a_cnt_max: assert property (@(posedge clk) disable iff (rst)
        (count <= CW'(DEPTH + 2)));

endmodule
